vc_arbiter_rr: RTL and testbench
================================

Name: vc_arbiter_rr

Overview:
Weighted round-robin scheduler that drains four virtual-channel FIFOs (VC0..VC3) into one shared destination FIFO.
- It sits between the VC FIFOs and the destination FIFO.
- It is enabled by the transaction controller's active indication.
- It is throttled by the destination FIFO's almost-full flag, which is derived from that FIFO's configured threshold.
- One pop per cycle maximum, with zero bubbles between VCs.

Parameters:
DATA_WIDTH, 6, width of one FIFO word.
WEIGHT_W, 3, width of each per-VC burst weight.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
active_in  in  1  controller in ACTIVE state; arbitration allowed
cfg_load  in  1  load weights (accepted only in IDLE)
weights  in  4*WEIGHT_W  per-VC burst weight, VC0 in LSBs
vc_empty  in  4  empty flag per VC FIFO, bit i = VCi
vc_data  in  4*DATA_WIDTH  show-ahead head word per VC, VC0 in LSBs
dest_almost_full  in  1  destination FIFO at/above threshold
vc_pop  out  4  one-hot (or zero) pop strobe, combinational
dest_push  out  1  registered write strobe to destination
dest_data  out  DATA_WIDTH  registered word written to destination
grant  out  2  registered index of the VC last popped
arb_state  out  2  current FSM state encoding

Behaviour:
- Reset (clk edge with reset=1) sets all of the following; reset mid-operation discards any burst in progress:
  - arb_state=IDLE, curr=3 (so the first grant goes to VC0), burst_cnt=0.
  - All four weights=1 (pure round-robin).
  - dest_push=0, dest_data=0, grant=0.
- FSM states: IDLE=0, SERVE=1, STALL=2. Encoding 3 is illegal and returns to IDLE on the next clock.
  - IDLE -> SERVE: active_in=1 and vc_empty!=4'b1111 and dest_almost_full=0.
  - IDLE -> STALL: active_in=1, some VC non-empty, dest_almost_full=1.
  - SERVE -> STALL: dest_almost_full=1.
  - SERVE -> IDLE: active_in=0, or all VCs empty.
  - STALL -> SERVE: dest_almost_full=0 and some VC non-empty.
  - STALL -> IDLE: active_in=0.
- Eligibility: a pop is eligible in the current cycle only if all of these hold:
  - active_in=1 and dest_almost_full=0, both evaluated in the same cycle.
  - The FSM is in SERVE, or is leaving IDLE/STALL toward SERVE.
  - At least one VC is non-empty.
- Selection (combinational, same cycle):
  - Effective weight w_i = max(weights_i, 1); weight 0 is treated as 1.
  - If vc_empty[curr]=0 and burst_cnt < w_curr: select curr.
  - Otherwise select the first non-empty VC in order curr+1, curr+2, curr+3, curr (mod 4), and treat burst_cnt as 0.
- On an eligible cycle:
  - vc_pop = one-hot of the selected VC.
  - curr <= selected VC.
  - burst_cnt <= (same VC continued ? burst_cnt+1 : 1).
- Output latency: one cycle.
  - dest_push <= |vc_pop.
  - dest_data <= vc_data slice of the selected VC, captured in the pop cycle.
  - grant <= selected index, updated only on a pop.
  - dest_push=0 on every non-pop cycle; dest_data holds its last value.
- Boundaries:
  - dest_almost_full rising in the same cycle as a candidate pop: no pop that cycle.
  - active_in falling mid-burst: no pop that cycle. burst_cnt clears to 0; curr is kept.
  - The current VC going empty mid-burst: the next non-empty VC is served in the same cycle, with no bubble.
  - A single non-empty VC with w=2: served every cycle (the counter wraps to 1 on re-selection of the same VC).
  - cfg_load outside IDLE: ignored; weights unchanged.
  - cfg_load in IDLE: the new weights take effect from the next cycle.
- Widths: burst_cnt is WEIGHT_W bits and saturates at 2^WEIGHT_W-1. Index arithmetic is mod 4 using the 2-bit wrap.

Decomposition:
- Shared package holds:
  - the state constants IDLE/SERVE/STALL;
  - NUM_VC=4;
  - the VC index width (2).
- One natural sub-module: rr_next_sel, a combinational 4-way priority rotate. Inputs: curr and the non-empty mask. Outputs: next index and a found flag.

Test Plan:
- Reset, then active_in=1, all weights 1, each VC holds 2 words, dest_almost_full=0 -> pops VC0,1,2,3,0,1,2,3 on consecutive cycles; dest_push high 8 cycles, starting 1 cycle after the first pop; grant sequence 0,1,2,3,0,1,2,3.
- cfg_load in IDLE with weights {VC3..VC0}={1,1,1,3}, each VC holds 4 words -> grant sequence 0,0,0,1,2,3,0,...
- dest_almost_full=1 for 3 cycles mid-burst -> vc_pop=0 and arb_state=STALL for those 3 cycles. On release, service resumes on the same VC with the remaining burst count.
- Only VC2 non-empty (5 words), weight 2 -> 5 consecutive VC2 pops, then arb_state returns to IDLE; dest_data matches the 5 words in order.
- cfg_load while in SERVE -> weights unchanged; arbitration order identical to the pre-load order.
- reset asserted mid-burst on VC1 -> next cycle: arb_state=IDLE, dest_push=0, grant=0. The first pop after release goes to VC0.

Source files
------------

// File: rtl/vc_arbiter_rr_pkg.sv
// Shared definitions for the weighted round-robin VC drain scheduler.
package vc_arbiter_rr_pkg;

  localparam int NUM_VC   = 4;
  localparam int VC_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    STALL   = 2'd2,
    ILLEGAL = 2'd3
  } arb_state_t;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VC_IDX_W-1:0] idx);
    logic [NUM_VC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_arbiter_rr_rr_next_sel.sv
// Rotating priority pick: first non-empty VC after curr, wrapping back to curr itself.
module rr_next_sel
  import vc_arbiter_rr_pkg::*;
(
  input  logic [VC_IDX_W-1:0] curr,
  input  logic [NUM_VC-1:0]   nonempty,
  output logic [VC_IDX_W-1:0] next_idx,
  output logic                found
);

  logic [VC_IDX_W-1:0] cand;

  // Scan farthest-first so the nearest candidate overwrites the rest.
  always_comb begin
    next_idx = curr;
    cand     = curr;
    found    = |nonempty;
    for (int k = NUM_VC; k >= 1; k--) begin
      cand = curr + VC_IDX_W'(k);
      if (nonempty[cand]) next_idx = cand;
    end
  end

endmodule

// File: rtl/vc_arbiter_rr.sv
// Weighted round-robin drain of four VC FIFOs into one destination FIFO, one pop per cycle.
// Pop strobe is combinational; the destination write is registered one cycle later.
module vc_arbiter_rr
  import vc_arbiter_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int WEIGHT_W   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active_in,
  input  logic                         cfg_load,
  input  logic [NUM_VC*WEIGHT_W-1:0]   weights,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] vc_data,
  input  logic                         dest_almost_full,
  output logic [NUM_VC-1:0]            vc_pop,
  output logic                         dest_push,
  output logic [DATA_WIDTH-1:0]        dest_data,
  output logic [VC_IDX_W-1:0]          grant,
  output logic [1:0]                   arb_state
);

  arb_state_t          state, state_nxt;
  logic [VC_IDX_W-1:0] curr, rr_idx, sel;
  logic [WEIGHT_W-1:0] burst_cnt, burst_nxt, w_curr;
  logic [WEIGHT_W-1:0] weight_q [NUM_VC];
  logic [NUM_VC-1:0]   nonempty;
  logic                any_ne, cont, pop_ok;

  assign nonempty  = ~vc_empty;
  assign arb_state = state;

  rr_next_sel u_next_sel (
    .curr     (curr),
    .nonempty (nonempty),
    .next_idx (rr_idx),
    .found    (any_ne)
  );

  // A zero burst count means no burst is open, so reset (curr=3) hands VC0 the first grant.
  always_comb begin
    w_curr    = (weight_q[curr] == '0) ? WEIGHT_W'(1) : weight_q[curr];
    cont      = !vc_empty[curr] && (burst_cnt != '0) && (burst_cnt < w_curr);
    sel       = cont ? curr : rr_idx;
    burst_nxt = WEIGHT_W'(1);
    if (cont) burst_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + WEIGHT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (active_in && any_ne) state_nxt = dest_almost_full ? STALL : SERVE;
      end
      SERVE: begin
        if (!active_in || !any_ne) state_nxt = IDLE;
        else if (dest_almost_full) state_nxt = STALL;
      end
      STALL: begin
        if (!active_in)                         state_nxt = IDLE;
        else if (!dest_almost_full && any_ne)   state_nxt = SERVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pops are held off while reset is applied so no FIFO word is lost.
  always_comb begin
    pop_ok = !reset && active_in && !dest_almost_full && any_ne &&
             ((state == SERVE) || (state_nxt == SERVE));
    vc_pop = pop_ok ? vc_onehot(sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr      <= VC_IDX_W'(NUM_VC - 1);
      burst_cnt <= '0;
      dest_push <= 1'b0;
      dest_data <= '0;
      grant     <= '0;
      for (int i = 0; i < NUM_VC; i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      dest_push <= pop_ok;
      if (pop_ok) begin
        curr      <= sel;
        burst_cnt <= burst_nxt;
        grant     <= sel;
        dest_data <= vc_data[sel*DATA_WIDTH +: DATA_WIDTH];
      end else if (!active_in) begin
        burst_cnt <= '0;
      end
      if (cfg_load && (state == IDLE)) begin
        for (int i = 0; i < NUM_VC; i++) weight_q[i] <= weights[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter_rr.sv
// Directed bench for vc_arbiter_rr with a small show-ahead FIFO model per VC.
module tb_vc_arbiter_rr;

  logic        clk = 1'b0;
  logic        reset, active_in, cfg_load, dest_almost_full;
  logic [11:0] weights;
  logic [3:0]  vc_empty, vc_pop;
  logic [23:0] vc_data;
  logic        dest_push;
  logic [5:0]  dest_data;
  logic [1:0]  grant, arb_state;

  int checks   = 0;
  int failures = 0;

  logic [5:0] mem [4][16];
  int         rd [4];
  int         wr [4];
  logic [3:0] pop_now;

  always #5 clk = ~clk;

  vc_arbiter_rr #(.DATA_WIDTH(6), .WEIGHT_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .active_in        (active_in),
    .cfg_load         (cfg_load),
    .weights          (weights),
    .vc_empty         (vc_empty),
    .vc_data          (vc_data),
    .dest_almost_full (dest_almost_full),
    .vc_pop           (vc_pop),
    .dest_push        (dest_push),
    .dest_data        (dest_data),
    .grant            (grant),
    .arb_state        (arb_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_vc();
    for (int i = 0; i < 4; i++) begin
      vc_empty[i]       = (rd[i] == wr[i]);
      vc_data[i*6 +: 6] = (rd[i] == wr[i]) ? 6'd0 : mem[i][rd[i]];
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    update_vc();
  endtask

  task automatic push(input int vc, input logic [5:0] d);
    mem[vc][wr[vc]] = d;
    wr[vc]++;
  endtask

  // Inputs are stable from edge+2 to the next edge; checks happen in that window.
  task automatic tick();
    pop_now = vc_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pop_now[i] === 1'b1) rd[i]++;
    update_vc();
    #1;
  endtask

  int e1 [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e2 [16] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1, 2, 3};
  int e5 [6]  = '{0, 1, 0, 1, 0, 1};
  int cnt [4];

  initial begin
    reset = 1'b1; active_in = 1'b0; cfg_load = 1'b0; dest_almost_full = 1'b0;
    weights = '0;
    flush();
    tick();
    tick();
    chk("rst_state", arb_state, 0);
    chk("rst_push",  dest_push, 0);
    chk("rst_data",  dest_data, 0);
    chk("rst_grant", grant, 0);
    reset = 1'b0;
    #1;
    chk("rst_pop", vc_pop, 0);

    // Pure round robin, two words per VC.
    for (int v = 0; v < 4; v++) for (int j = 0; j < 2; j++) push(v, 6'(v*8 + j));
    update_vc();
    active_in = 1'b1;
    #1;
    chk("t1_push_pre", dest_push, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_pop%0d", k), vc_pop, 32'(1) << e1[k]);
      tick();
      chk($sformatf("t1_push%0d", k), dest_push, 1);
      chk($sformatf("t1_grant%0d", k), grant, e1[k]);
      chk($sformatf("t1_data%0d", k), dest_data, e1[k]*8 + k/4);
    end
    chk("t1_pop_end", vc_pop, 0);
    tick();
    chk("t1_push_end", dest_push, 0);
    chk("t1_idle", arb_state, 0);
    chk("t1_hold", dest_data, 25);

    // VC0 weight 3, four words per VC.
    weights = {3'd1, 3'd1, 3'd1, 3'd3};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    weights = '0;
    flush();
    for (int v = 0; v < 4; v++) begin
      cnt[v] = 0;
      for (int j = 0; j < 4; j++) push(v, 6'(v*8 + j));
    end
    update_vc();
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_pop%0d", k), vc_pop, 32'(1) << e2[k]);
      tick();
      chk($sformatf("t2_grant%0d", k), grant, e2[k]);
      chk($sformatf("t2_data%0d", k), dest_data, e2[k]*8 + cnt[e2[k]]);
      cnt[e2[k]]++;
    end
    tick();

    // Almost-full stall in the middle of a VC0 burst.
    flush();
    for (int v = 0; v < 4; v++) for (int j = 0; j < 4; j++) push(v, 6'(v*8 + j));
    update_vc();
    #1;
    chk("t3_popA", vc_pop, 1);
    tick();
    chk("t3_popB", vc_pop, 1);
    tick();
    dest_almost_full = 1'b1;
    #1;
    chk("t3_stall_pop0", vc_pop, 0);
    chk("t3_state_serve", arb_state, 1);
    tick();
    chk("t3_stall_push", dest_push, 0);
    chk("t3_state_stall1", arb_state, 2);
    chk("t3_stall_pop1", vc_pop, 0);
    tick();
    chk("t3_state_stall2", arb_state, 2);
    chk("t3_stall_pop2", vc_pop, 0);
    tick();
    chk("t3_state_stall3", arb_state, 2);
    dest_almost_full = 1'b0;
    #1;
    chk("t3_resume_pop", vc_pop, 1);
    tick();
    chk("t3_resume_grant", grant, 0);
    chk("t3_resume_data", dest_data, 2);
    chk("t3_next_pop", vc_pop, 2);
    tick();
    chk("t3_next_grant", grant, 1);
    active_in = 1'b0;
    #1;
    chk("t3_inactive_pop", vc_pop, 0);
    tick();
    chk("t3_inactive_state", arb_state, 0);
    chk("t3_inactive_push", dest_push, 0);
    flush();

    // Single non-empty VC2 with weight 2.
    weights = {3'd1, 3'd2, 3'd1, 3'd1};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int j = 0; j < 5; j++) push(2, 6'(40 + j));
    update_vc();
    active_in = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("t4_pop%0d", j), vc_pop, 4);
      tick();
      chk($sformatf("t4_push%0d", j), dest_push, 1);
      chk($sformatf("t4_grant%0d", j), grant, 2);
      chk($sformatf("t4_data%0d", j), dest_data, 40 + j);
    end
    chk("t4_pop_end", vc_pop, 0);
    tick();
    chk("t4_idle", arb_state, 0);
    chk("t4_push_end", dest_push, 0);

    // cfg_load while serving must be ignored.
    flush();
    for (int v = 0; v < 2; v++) for (int j = 0; j < 3; j++) push(v, 6'(v*8 + j));
    update_vc();
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t5_pop%0d", k), vc_pop, 32'(1) << e5[k]);
      tick();
      chk($sformatf("t5_grant%0d", k), grant, e5[k]);
      if (k == 0) begin
        weights = {3'd3, 3'd3, 3'd3, 3'd3};
        cfg_load = 1'b1;
        #1;
      end
    end
    cfg_load = 1'b0;
    weights = '0;
    tick();
    chk("t5_idle", arb_state, 0);

    // active_in drop mid-burst clears the burst; curr is kept.
    flush();
    for (int j = 0; j < 3; j++) begin
      push(2, 6'(48 + j));
      push(3, 6'(56 + j));
    end
    update_vc();
    #1;
    chk("t6_pop_vc2", vc_pop, 4);
    tick();
    active_in = 1'b0;
    #1;
    chk("t6_drop_pop", vc_pop, 0);
    tick();
    chk("t6_drop_state", arb_state, 0);
    active_in = 1'b1;
    #1;
    chk("t6_after_pop", vc_pop, 8);
    tick();
    chk("t6_after_grant", grant, 3);
    chk("t6_after_data", dest_data, 56);
    active_in = 1'b0;
    tick();
    flush();

    // Reset in the middle of a VC1 burst.
    weights = {3'd1, 3'd1, 3'd3, 3'd1};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int j = 0; j < 2; j++) push(0, 6'(j));
    for (int j = 0; j < 4; j++) push(1, 6'(8 + j));
    update_vc();
    active_in = 1'b1;
    #1;
    chk("t7_pop0", vc_pop, 1);
    tick();
    chk("t7_pop1", vc_pop, 2);
    tick();
    chk("t7_pop2", vc_pop, 2);
    tick();
    chk("t7_grant_pre", grant, 1);
    reset = 1'b1;
    #1;
    tick();
    chk("t7_rst_state", arb_state, 0);
    chk("t7_rst_push", dest_push, 0);
    chk("t7_rst_grant", grant, 0);
    reset = 1'b0;
    #1;
    chk("t7_first_pop", vc_pop, 1);
    tick();
    chk("t7_first_grant", grant, 0);
    chk("t7_first_data", dest_data, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
